// File: rtl/mult_share_pkg.sv
// Shared types and defaults for the time-shared multiplier controller.
package mult_share_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   localparam int DEF_NREQ    = 4;
   localparam int DEF_W       = 4;
   localparam int DEF_TIMEOUT = 31;
   localparam int WD_W        = 6;

endpackage

// File: rtl/mult_rr_pick.sv
// Combinational round-robin picker: first valid index at or after rr_ptr, wrapping.
module mult_rr_pick #(
   parameter int NREQ  = 4,
   parameter int PTR_W = 2
) (
   input  logic [NREQ-1:0]  req_valid,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [NREQ-1:0]  grant,
   output logic             any_valid
);

   logic [PTR_W-1:0] idx;
   logic             found;

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      grant = '0;
      found = 1'b0;
      idx   = '0;
      for (int i = 0; i < NREQ; i++) begin
         idx = PTR_W'((int'(rr_ptr) + i) % NREQ);
         if (!found && req_valid[idx]) begin
            grant[idx] = 1'b1;
            found      = 1'b1;
         end
      end
   end

   assign any_valid = |req_valid;

endmodule

// File: rtl/mult_share_ctrl.sv
// Round-robin controller sharing one sequential multiplier among NREQ requesters,
// with a watchdog that converts a missing done pulse into an error response.
module mult_share_ctrl
   import mult_share_pkg::*;
#(
   parameter int NREQ    = DEF_NREQ,
   parameter int W       = DEF_W,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NREQ-1:0]         req_valid,
   output logic [NREQ-1:0]         req_ready,
   input  logic [NREQ*W-1:0]       req_a,
   input  logic [NREQ*W-1:0]       req_b,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [$clog2(NREQ)-1:0] rsp_id,
   output logic [2*W-1:0]          rsp_p,
   output logic                    rsp_err,
   output logic                    mul_load,
   output logic [W-1:0]            mul_m1,
   output logic [W-1:0]            mul_m2,
   input  logic                    mul_done,
   input  logic [2*W-1:0]          mul_out,
   output logic                    busy,
   output logic                    err_sticky
);

   localparam int ID_W = $clog2(NREQ);

   state_t          state, state_nx;
   logic [ID_W-1:0] rr_ptr, id_q, grant_idx, next_ptr;
   logic [NREQ-1:0] grant;
   logic            any_req;
   logic [W-1:0]    sel_a, sel_b, op_a, op_b;
   logic [WD_W-1:0] wd_cnt;
   logic [2*W-1:0]  p_q;
   logic            err_q, sticky_q, timeout_hit;

   mult_rr_pick #(.NREQ(NREQ), .PTR_W(ID_W)) u_pick (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (grant),
      .any_valid (any_req)
   );

   always_comb begin
      grant_idx = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (grant[i]) begin
            grant_idx = ID_W'(i);
            sel_a     = req_a[i*W +: W];
            sel_b     = req_b[i*W +: W];
         end
      end
   end

   assign next_ptr    = (grant_idx == ID_W'(NREQ-1)) ? '0 : grant_idx + 1'b1;
   // Fires on the WAIT cycle where the counter reads TIMEOUT, i.e. after TIMEOUT idle WAIT cycles.
   assign timeout_hit = (wd_cnt == WD_W'(TIMEOUT));

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx  = state;
      req_ready = '0;
      mul_load  = 1'b0;
      mul_m1    = '0;
      mul_m2    = '0;
      case (state)
         ST_IDLE: begin
            req_ready = grant;
            if (any_req) state_nx = ST_ISSUE;
         end
         ST_ISSUE: begin
            mul_load = 1'b1;
            mul_m1   = op_a;
            mul_m2   = op_b;
            state_nx = ST_WAIT;
         end
         ST_WAIT: begin
            mul_m1 = op_a;
            mul_m2 = op_b;
            if (mul_done || timeout_hit) state_nx = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_ready) state_nx = ST_IDLE;
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   // NOTE: every datapath register is reset here; there is no memory array that would need to stay unreset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr   <= '0;
         id_q     <= '0;
         op_a     <= '0;
         op_b     <= '0;
         wd_cnt   <= '0;
         p_q      <= '0;
         err_q    <= 1'b0;
         sticky_q <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (any_req) begin
                  op_a   <= sel_a;
                  op_b   <= sel_b;
                  id_q   <= grant_idx;
                  rr_ptr <= next_ptr;
               end
            end
            ST_ISSUE: wd_cnt <= '0;
            ST_WAIT: begin
               wd_cnt <= wd_cnt + 1'b1;
               if (mul_done) begin
                  p_q   <= mul_out;
                  err_q <= 1'b0;
               end else if (timeout_hit) begin
                  p_q      <= '0;
                  err_q    <= 1'b1;
                  sticky_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign rsp_valid  = (state == ST_RESP);
   assign busy       = (state != ST_IDLE);
   assign rsp_id     = id_q;
   assign rsp_p      = p_q;
   assign rsp_err    = err_q;
   assign err_sticky = sticky_q;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a behavioural multiplier and a response scoreboard.
module tb_mult_share_ctrl;

   localparam int NREQ    = 4;
   localparam int W       = 4;
   localparam int TIMEOUT = 31;
   localparam int ID_W    = 2;
   localparam int P_W     = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*W-1:0] req_a, req_b;
   logic              rsp_valid, rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [P_W-1:0]    rsp_p;
   logic              rsp_err;
   logic              mul_load;
   logic [W-1:0]      mul_m1, mul_m2;
   logic              mul_done;
   logic [P_W-1:0]    mul_out;
   logic              busy, err_sticky;

   logic              model_done, man_done;
   logic [P_W-1:0]    model_out, man_out;
   logic              mul_en;
   int                mul_delay;

   assign mul_done = model_done | man_done;
   assign mul_out  = man_done ? man_out : model_out;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [P_W-1:0]  p;
      logic            err;
   } rsp_t;

   rsp_t sb[$];
   int   grant_log[$];
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mult_share_ctrl #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_p      (rsp_p),
      .rsp_err    (rsp_err),
      .mul_load   (mul_load),
      .mul_m1     (mul_m1),
      .mul_m2     (mul_m2),
      .mul_done   (mul_done),
      .mul_out    (mul_out),
      .busy       (busy),
      .err_sticky (err_sticky)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rsp_valid"},  32'(rsp_valid),  32'(0));
      check({tag, "_busy"},       32'(busy),       32'(0));
      check({tag, "_mul_load"},   32'(mul_load),   32'(0));
      check({tag, "_req_ready"},  32'(req_ready),  32'(0));
      check({tag, "_rsp_id"},     32'(rsp_id),     32'(0));
      check({tag, "_rsp_p"},      32'(rsp_p),      32'(0));
      check({tag, "_rsp_err"},    32'(rsp_err),    32'(0));
      check({tag, "_mul_m1"},     32'(mul_m1),     32'(0));
      check({tag, "_mul_m2"},     32'(mul_m2),     32'(0));
      check({tag, "_err_sticky"}, 32'(err_sticky), 32'(0));
   endtask

   // Presents a request from requester i; returns one cycle after the handshake edge.
   task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [NREQ-1:0] exp_ready);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_valid[i]    = 1'b1;
      #1;
      check("grant", 32'(req_ready), 32'(exp_ready));
      tick(1);
      req_valid[i] = 1'b0;
   endtask

   task automatic wait_rsp(input int bound, output int cyc);
      cyc = 0;
      while (!rsp_valid && cyc < bound) begin
         tick(1);
         cyc++;
      end
      check("rsp_arrived", 32'(rsp_valid), 32'(1));
   endtask

   // Behavioural multiplier: done pulse mul_delay cycles after the load cycle.
   initial begin
      logic signed [W-1:0]   a, b;
      logic signed [P_W-1:0] pr;
      model_done = 1'b0;
      model_out  = '0;
      forever begin
         @(posedge clk);
         #1;
         if (mul_load && mul_en && !rst) begin
            a  = mul_m1;
            b  = mul_m2;
            pr = a * b;
            repeat (mul_delay) begin
               @(posedge clk);
               #1;
            end
            model_out  = pr;
            model_done = 1'b1;
            @(posedge clk);
            #1;
            model_done = 1'b0;
         end
      end
   end

   // Scoreboard: push on request handshake, pop on response handshake.
   initial begin
      rsp_t                  e;
      logic [NREQ-1:0]       hs;
      logic signed [W-1:0]   ea, eb;
      logic signed [P_W-1:0] ep;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (req_valid != '0) check("req_ready_onehot", 32'($onehot0(req_ready)), 32'(1));
            hs = req_valid & req_ready;
            for (int i = 0; i < NREQ; i++) begin
               if (hs[i]) begin
                  ea    = req_a[i*W +: W];
                  eb    = req_b[i*W +: W];
                  ep    = ea * eb;
                  e.id  = ID_W'(i);
                  e.p   = mul_en ? ep : '0;
                  e.err = !mul_en;
                  sb.push_back(e);
                  grant_log.push_back(i);
               end
            end
            if (rsp_valid && rsp_ready) begin
               if (sb.size() == 0) begin
                  check("rsp_unexpected", 32'(rsp_valid), 32'(0));
               end else begin
                  e = sb.pop_front();
                  check("rsp_id",  32'(rsp_id),  32'(e.id));
                  check("rsp_p",   32'(rsp_p),   32'(e.p));
                  check("rsp_err", 32'(rsp_err), 32'(e.err));
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "simulation time limit");
   end

   initial begin
      int cyc;
      rst       = 1'b1;
      req_valid = '0;
      req_a     = '0;
      req_b     = '0;
      rsp_ready = 1'b1;
      man_done  = 1'b0;
      man_out   = '0;
      mul_en    = 1'b1;
      mul_delay = 6;

      tick(3);
      check_all_zero("reset");
      rst = 1'b0;
      tick(1);

      // Requester 0: 3*5, done 6 cycles after load, response one cycle after done.
      issue(0, 4'd3, 4'd5, 4'b0001);
      check("t1_load",  32'(mul_load), 32'(1));
      check("t1_m1",    32'(mul_m1),   32'(3));
      check("t1_m2",    32'(mul_m2),   32'(5));
      tick(1);
      check("t1_load_pulse", 32'(mul_load), 32'(0));
      check("t1_m1_hold",    32'(mul_m1),   32'(3));
      check("t1_busy",       32'(busy),     32'(1));
      wait_rsp(40, cyc);
      check("t1_latency", 32'(cyc), 32'(mul_delay));
      check("t1_p_direct", 32'(rsp_p), 32'(8'h0F));
      tick(1);
      check("t1_idle", 32'(busy), 32'(0));

      // Requester 2 with signed operands; second request wraps the pointer back to 2.
      issue(2, 4'hE, 4'h3, 4'b0100);
      wait_rsp(40, cyc);
      check("t2_p_direct", 32'(rsp_p), 32'(8'hFA));
      tick(1);
      issue(2, 4'h8, 4'h8, 4'b0100);
      wait_rsp(40, cyc);
      check("t2b_p_direct", 32'(rsp_p), 32'(8'h40));
      tick(1);

      // Reset restores rr_ptr=0, then all four requesters compete continuously.
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      tick(1);
      mul_delay = 2;
      grant_log.delete();
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*W +: W] = W'(i + 1);
         req_b[i*W +: W] = W'(13 - i);
      end
      req_valid = '1;
      cyc = 0;
      while (grant_log.size() < 6 && cyc < 200) begin
         tick(1);
         cyc++;
      end
      req_valid = '0;
      check("rr_grants_seen", 32'(grant_log.size()), 32'(6));
      cyc = 0;
      while (sb.size() != 0 && cyc < 50) begin
         tick(1);
         cyc++;
      end
      check("rr_drained", 32'(sb.size()), 32'(0));
      for (int k = 0; k < 6 && k < grant_log.size(); k++)
         check("rr_order", 32'(grant_log[k]), 32'(k % NREQ));

      // Backpressure: response held for 10 cycles with another requester waiting.
      rsp_ready = 1'b0;
      issue(1, 4'h5, 4'hD, 4'b0010);
      wait_rsp(40, cyc);
      req_a[3*W +: W] = 4'h2;
      req_b[3*W +: W] = 4'h2;
      req_valid[3]    = 1'b1;
      for (int k = 0; k < 10; k++) begin
         #1;
         check("bp_valid",     32'(rsp_valid), 32'(1));
         check("bp_id",        32'(rsp_id),    32'(1));
         check("bp_p",         32'(rsp_p),     32'(8'hF1));
         check("bp_req_ready", 32'(req_ready), 32'(0));
         check("bp_busy",      32'(busy),      32'(1));
         tick(1);
      end
      rsp_ready = 1'b1;
      tick(1);
      check("bp_release_idle",  32'(busy),      32'(0));
      check("bp_release_grant", 32'(req_ready), 32'(4'b1000));
      tick(1);
      req_valid[3] = 1'b0;
      wait_rsp(40, cyc);
      tick(1);

      // Watchdog: one ISSUE cycle plus TIMEOUT+1 WAIT cycles before RESP.
      mul_en = 1'b0;
      issue(0, 4'h1, 4'h1, 4'b0001);
      wait_rsp(100, cyc);
      check("to_latency",   32'(cyc),        32'(TIMEOUT + 2));
      check("to_err",       32'(rsp_err),    32'(1));
      check("to_p",         32'(rsp_p),      32'(0));
      check("to_sticky",    32'(err_sticky), 32'(1));
      tick(1);
      mul_en = 1'b1;
      issue(1, 4'h2, 4'h3, 4'b0010);
      wait_rsp(40, cyc);
      check("post_to_err",    32'(rsp_err),    32'(0));
      check("post_to_sticky", 32'(err_sticky), 32'(1));
      tick(1);

      // Reset during WAIT, then a stale done pulse must be ignored.
      mul_en = 1'b0;
      issue(2, 4'h3, 4'h3, 4'b0100);
      tick(4);
      check("mid_busy", 32'(busy), 32'(1));
      rst = 1'b1;
      #1;
      check_all_zero("mid_reset");
      sb.delete();
      tick(1);
      rst = 1'b0;
      tick(2);
      man_out  = 8'h55;
      man_done = 1'b1;
      tick(1);
      man_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         check("stale_rsp_valid", 32'(rsp_valid), 32'(0));
         check("stale_busy",      32'(busy),      32'(0));
         tick(1);
      end
      check("stale_rsp_p", 32'(rsp_p), 32'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
Controller that time-shares one sequential 4x4 signed shift-add multiplier among NREQ requesters. Round-robin arbitration picks a requester, latches its operands, pulses the multiplier's load, and waits for its one-cycle done pulse. It returns the 8-bit product tagged with the requester index over a valid/ready response channel. A watchdog turns a missing done into an error response.

Parameters:
NREQ, 4, number of requesters (2..8)
W, 4, operand width; product width is 2*W
TIMEOUT, 31, maximum WAIT cycles before error (fits in 6-bit counter)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
req_valid  in  NREQ  per-requester request valid
req_ready  out  NREQ  per-requester accept; one-hot, at most one bit high
req_a  in  NREQ*W  operand A per requester, slice i = bits [i*W +: W], signed
req_b  in  NREQ*W  operand B per requester, slice i, signed
rsp_valid  out  1  response valid
rsp_ready  in  1  response consumer ready
rsp_id  out  clog2(NREQ)  index of the served requester
rsp_p  out  2*W  product
rsp_err  out  1  response caused by a timeout
mul_load  out  1  start pulse to the multiplier
mul_m1  out  W  multiplier operand 1
mul_m2  out  W  multiplier operand 2
mul_done  in  1  multiplier done pulse
mul_out  in  2*W  multiplier product, valid while mul_done=1
busy  out  1  high in any state other than IDLE
err_sticky  out  1  set on any timeout, cleared only by rst

Behaviour:
- Reset values: all outputs 0; rr_ptr=0; state=IDLE.
- States: IDLE, ISSUE, WAIT, RESP. Binary encoding.
- IDLE:
  - If any req_valid is high, grant the first set index at or after rr_ptr, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that cycle; the handshake is req_valid[g] & req_ready[g].
  - On the handshake: latch op_a/op_b from slice g, latch id=g, set rr_ptr=(g+1) mod NREQ, go to ISSUE.
  - Otherwise stay in IDLE with req_ready all 0.
- ISSUE:
  - mul_load=1 for exactly this one cycle.
  - mul_m1=op_a and mul_m2=op_b. Both are held stable in ISSUE and WAIT and are 0 elsewhere.
  - Clear the watchdog counter and go to WAIT.
  - mul_done in this cycle is ignored.
- WAIT:
  - mul_load=0; the watchdog increments each cycle.
  - On mul_done=1: capture mul_out into rsp_p, set rsp_err=0, go to RESP.
  - Otherwise, when the watchdog equals TIMEOUT: set rsp_p=0, rsp_err=1, err_sticky=1, go to RESP.
  - If mul_done and the timeout occur in the same cycle, mul_done wins.
- RESP:
  - rsp_valid=1. rsp_id, rsp_p and rsp_err are held stable until rsp_valid & rsp_ready, then go to IDLE.
  - rsp_ready has no combinational path to any output.
  - No request is accepted in RESP.
  - mul_done arriving in RESP or IDLE is ignored.
- Latency:
  - Handshake at cycle T, mul_load at T+1.
  - mul_done at cycle D gives rsp_valid at D+1.
  - Earliest next accept is the cycle after the response handshake.
- Fairness: a continuously requesting requester is served within NREQ grants.
- Requester contract: req_a/req_b must be stable while req_valid is high. A requester dropping req_valid before the handshake loses no state.
- Reset mid-operation: returns immediately to IDLE with all outputs 0. A later stale mul_done is ignored.
- The product is passed through unmodified. Signed 2*W interpretation is the multiplier's responsibility.

Decomposition:
- Package mult_share_pkg: state encoding constants (ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP), default widths, and the watchdog counter width.
- One sub-module, mult_rr_pick: combinational round-robin picker. Inputs are the req_valid vector and rr_ptr; outputs are a one-hot grant and an any flag.

Test Plan:
- Req 0 with a=3, b=5; model multiplier gives done after 6 cycles -> mul_load 1 cycle with m1=3, m2=5; rsp_valid, rsp_id=0, rsp_p=0x0F, rsp_err=0.
- Req 2 with a=-2 (0xE), b=3 -> rsp_id=2, rsp_p=0xFA; a=-8, b=-8 -> rsp_p=0x40.
- All 4 requesters valid continuously with rsp_ready=1 -> grant order 0,1,2,3,0,1; req_ready always one-hot.
- rsp_ready held low 10 cycles after rsp_valid -> rsp_id/rsp_p stable throughout, req_ready stays 0, busy=1; released -> IDLE next cycle.
- mul_done never asserted -> after TIMEOUT cycles in WAIT: rsp_valid=1, rsp_err=1, rsp_p=0, err_sticky=1. A following normal request completes with rsp_err=0 while err_sticky stays 1.
- rst asserted during WAIT, mul_done pulsed 2 cycles after release -> all outputs 0, state IDLE, no rsp_valid generated.
